// File: rtl/car_kill_eraser_pkg.sv
// Shared constants, field helpers and FSM encoding for the car-kill eraser
// and the sprite stages built around the same frame-buffer coordinate format.
package car_kill_eraser_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 15;
  localparam int COLOUR_W = 9;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int X_MSB    = 14;
  localparam int X_LSB    = 7;
  localparam int Y_MSB    = 6;
  localparam int Y_LSB    = 0;
  localparam int NUM_CARS = 4;
  localparam int CAR_IDX_W = 2;
  // Sprite offsets never exceed 7, since sprites are at most 8x8.
  localparam int SCAN_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SCAN,
    ST_ERASE,
    ST_DONE
  } state_e;

  function automatic logic [X_W-1:0] coord_x(input logic [COORD_W-1:0] c);
    return c[X_MSB:X_LSB];
  endfunction

  function automatic logic [Y_W-1:0] coord_y(input logic [COORD_W-1:0] c);
    return c[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/car_kill_eraser_if.sv
// Pixel-write port into the VGA writer: strobe plus {x, y} coordinate and colour.
interface car_kill_eraser_if;
  import car_kill_eraser_pkg::*;

  logic                erase_wren;
  logic [COORD_W-1:0]  coord;
  logic [COLOUR_W-1:0] colour;

  modport master (output erase_wren, output coord, output colour);
  modport slave  (input  erase_wren, input  coord, input  colour);
endinterface

// File: rtl/car_kill_eraser_sprite_scan_counter.sv
// Raster-order (dx inner, dy outer) offset counter across one CAR_W x CAR_H sprite.
module sprite_scan_counter
  import car_kill_eraser_pkg::*;
#(
  parameter int CAR_W = 4,
  parameter int CAR_H = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              step,
  output logic [SCAN_W-1:0] dx,
  output logic [SCAN_W-1:0] dy,
  output logic              last
);

  localparam logic [SCAN_W-1:0] DX_LAST = SCAN_W'(CAR_W - 1);
  localparam logic [SCAN_W-1:0] DY_LAST = SCAN_W'(CAR_H - 1);

  assign last = (dx == DX_LAST) && (dy == DY_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (start) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      if (dx == DX_LAST) begin
        dx <= '0;
        dy <= (dy == DY_LAST) ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_kill_eraser.sv
// Erases newly destroyed cars from the frame buffer one pixel per cycle and
// owns the authoritative car-alive mask and saturating kill counter.
module car_kill_eraser
  import car_kill_eraser_pkg::*;
#(
  parameter int CAR_W = 4,
  parameter int CAR_H = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stage_start,
  input  logic                  laser_draw_done,
  input  logic [NUM_CARS-1:0]   destroyed_cars,
  input  logic [COORD_W-1:0]    car_0_coords,
  input  logic [COORD_W-1:0]    car_1_coords,
  input  logic [COORD_W-1:0]    car_2_coords,
  input  logic [COORD_W-1:0]    car_3_coords,
  input  logic [COLOUR_W-1:0]   background_colour,
  car_kill_eraser_if.master     pix,
  output logic                  erase_done,
  output logic                  busy,
  output logic [NUM_CARS-1:0]   cars_alive,
  output logic [7:0]            kill_count
);

  localparam logic [SCAN_W-1:0] DX_LAST = SCAN_W'(CAR_W - 1);

  state_e                 state;
  logic [NUM_CARS-1:0]    dest_q;
  logic [NUM_CARS-1:0]    pending;
  logic [CAR_IDX_W-1:0]   cur_idx;
  logic [COORD_W-1:0]     snap [NUM_CARS];

  logic [SCAN_W-1:0]      dx, dy;
  logic                   last;
  logic                   scan_start, scan_step;

  logic [CAR_IDX_W-1:0]   sel_idx, pix_idx;
  logic [SCAN_W-1:0]      off_x, off_y;
  logic [X_W:0]           px;
  logic [Y_W:0]           py;
  logic                   on_screen;

  assign busy       = (state != ST_IDLE);
  assign scan_start = (state == ST_SCAN) && (pending != '0);
  assign scan_step  = (state == ST_ERASE);

  sprite_scan_counter #(
    .CAR_W (CAR_W),
    .CAR_H (CAR_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .step   (scan_step),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  // Output pixels are registered, so compute the pixel shown in the *next*
  // cycle: (0,0) of the newly selected car from SCAN, else the successor offset.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = CAR_IDX_W'(i);
    end

    pix_idx = cur_idx;
    off_x   = '0;
    off_y   = '0;
    if (state == ST_SCAN) begin
      pix_idx = sel_idx;
    end else if (dx == DX_LAST) begin
      off_y = dy + 1'b1;
    end else begin
      off_x = dx + 1'b1;
      off_y = dy;
    end

    px        = {1'b0, coord_x(snap[pix_idx])} + {{(X_W + 1 - SCAN_W){1'b0}}, off_x};
    py        = {1'b0, coord_y(snap[pix_idx])} + {{(Y_W + 1 - SCAN_W){1'b0}}, off_y};
    on_screen = (px < (X_W + 1)'(SCREEN_W)) && (py < (Y_W + 1)'(SCREEN_H));
  end

  // NOTE: the coordinate snapshot is pure datapath that is always written in
  // LATCH before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_LATCH) begin
      snap[0] <= car_0_coords;
      snap[1] <= car_1_coords;
      snap[2] <= car_2_coords;
      snap[3] <= car_3_coords;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      dest_q         <= '0;
      pending        <= '0;
      cur_idx        <= '0;
      cars_alive     <= '0;
      kill_count     <= '0;
      erase_done     <= 1'b0;
      pix.erase_wren <= 1'b0;
      pix.coord      <= '0;
      pix.colour     <= '0;
    end else begin
      erase_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stage_start) cars_alive <= '1;
          if (laser_draw_done) begin
            dest_q <= destroyed_cars;
            state  <= ST_LATCH;
          end
        end

        // cars_alive already reflects a same-cycle revive by now.
        ST_LATCH: begin
          pending <= dest_q & cars_alive;
          state   <= ST_SCAN;
        end

        ST_SCAN: begin
          if (pending == '0) begin
            erase_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cur_idx        <= sel_idx;
            state          <= ST_ERASE;
            pix.erase_wren <= on_screen;
            pix.coord      <= on_screen ? {px[X_W-1:0], py[Y_W-1:0]} : '0;
            pix.colour     <= on_screen ? background_colour : '0;
          end
        end

        ST_ERASE: begin
          if (last) begin
            pending[cur_idx]    <= 1'b0;
            cars_alive[cur_idx] <= 1'b0;
            if (kill_count != 8'hFF) kill_count <= kill_count + 8'd1;
            state          <= ST_SCAN;
            pix.erase_wren <= 1'b0;
            pix.coord      <= '0;
            pix.colour     <= '0;
          end else begin
            pix.erase_wren <= on_screen;
            pix.coord      <= on_screen ? {px[X_W-1:0], py[Y_W-1:0]} : '0;
            pix.colour     <= on_screen ? background_colour : '0;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_kill_eraser.sv
// Randomised scoreboard bench: expected pixel writes and done pulses are queued
// by a behavioural model at issue time and popped by an independent monitor.
module tb_car_kill_eraser;
  import car_kill_eraser_pkg::*;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int PIX = W * H;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stage_start = 1'b0;
  logic        laser_draw_done = 1'b0;
  logic [3:0]  destroyed_cars = '0;
  logic [14:0] car_xy [4];
  logic [8:0]  bg = '0;
  logic        erase_done, busy;
  logic [3:0]  cars_alive;
  logic [7:0]  kill_count;

  car_kill_eraser_if pix ();

  car_kill_eraser #(.CAR_W(W), .CAR_H(H)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .stage_start       (stage_start),
    .laser_draw_done   (laser_draw_done),
    .destroyed_cars    (destroyed_cars),
    .car_0_coords      (car_xy[0]),
    .car_1_coords      (car_xy[1]),
    .car_2_coords      (car_xy[2]),
    .car_3_coords      (car_xy[3]),
    .background_colour (bg),
    .pix               (pix),
    .erase_done        (erase_done),
    .busy              (busy),
    .cars_alive        (cars_alive),
    .kill_count        (kill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [14:0] coord;
    logic [8:0]  colour;
  } wr_t;

  wr_t  wq[$];
  int   dq[$];
  int   checks = 0;
  int   errors = 0;
  int   e_cnt  = 0;
  int   mon_cyc;
  wr_t  mon_w;
  logic [3:0] m_alive = '0;
  int   m_kill = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge counter: the interval after edge e is cycle e+1.
  always @(posedge clk) e_cnt <= e_cnt + 1;

  always @(negedge clk) begin
    if (resetn) begin
      mon_cyc = e_cnt + 1;
      if (pix.erase_wren) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {pix.coord, pix.colour}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_w = wq.pop_front();
          check("write", {32'(mon_cyc), pix.coord, pix.colour},
                         {32'(mon_w.cyc), mon_w.coord, mon_w.colour});
        end
      end else begin
        check("idle_bus_zero", {pix.coord, pix.colour}, '0);
      end
      if (erase_done) begin
        if (dq.size() == 0) check("unexpected_done", 32'(mon_cyc), 0);
        else check("done_cycle", 32'(mon_cyc), 32'(dq.pop_front()));
      end
    end
  end

  function automatic logic [14:0] xy(input int x, input int y);
    logic [7:0] xb = 8'(x);
    logic [6:0] yb = 7'(y);
    return {xb, yb};
  endfunction

  // Model: each hit live car, lowest index first, owns a 1+PIX cycle slot;
  // pixel (dx,dy) lands at k+3+slot*(PIX+1)+dy*W+dx if it is on screen.
  task automatic model_round(input int k, input logic [3:0] dest);
    int n = 0;
    logic [3:0] pend = dest & m_alive;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        for (int dy = 0; dy < H; dy++) begin
          for (int dx = 0; dx < W; dx++) begin
            int px = int'(car_xy[i][14:7]) + dx;
            int py = int'(car_xy[i][6:0]) + dy;
            if (px < 160 && py < 120) begin
              wr_t w;
              w.cyc = k + 3 + n * (PIX + 1) + dy * W + dx;
              w.coord = xy(px, py);
              w.colour = bg;
              wq.push_back(w);
            end
          end
        end
        n++;
        m_alive[i] = 1'b0;
        if (m_kill < 255) m_kill++;
      end
    end
    dq.push_back(k + 3 + n * (PIX + 1));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    stage_start = 1'b1;
    m_alive = 4'hF;
    @(negedge clk);
    stage_start = 1'b0;
  endtask

  task automatic run_round(input logic [3:0] dest, input bit with_start, input bit noise);
    int k;
    int budget = 0;
    @(negedge clk);
    stage_start = with_start;
    laser_draw_done = 1'b1;
    destroyed_cars = dest;
    k = e_cnt + 1;
    if (with_start) m_alive = 4'hF;
    noise = noise && ((dest & m_alive) != 0);
    model_round(k, dest);
    @(negedge clk);
    stage_start = 1'b0;
    laser_draw_done = 1'b0;
    destroyed_cars = 4'($urandom);
    check("busy_in_latch", busy, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) car_xy[i] = 15'($urandom);
    if (noise) begin
      @(negedge clk);
      stage_start = 1'b1;
      laser_draw_done = 1'b1;
      destroyed_cars = 4'hF;
      @(negedge clk);
      stage_start = 1'b0;
      laser_draw_done = 1'b0;
    end
    #1;
    while (dq.size() > 0 && budget < 400) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (dq.size() > 0) begin
      check("done_timeout", 0, 1);
      dq.delete();
    end
    @(negedge clk);
    #1;
    check("cars_alive", cars_alive, m_alive);
    check("kill_count", kill_count, 8'(m_kill));
    check("writes_outstanding", wq.size(), 0);
    check("busy_after_done", busy, 0);
    wq.delete();
  endtask

  task automatic reset_mid_erase();
    int k;
    int budget = 0;
    pulse_start();
    car_xy[0] = xy(30, 40);
    @(negedge clk);
    laser_draw_done = 1'b1;
    destroyed_cars = 4'b0001;
    k = e_cnt + 1;
    for (int p = 0; p < 5; p++) begin
      wr_t w;
      w.cyc = k + 3 + p;
      w.coord = xy(30 + p % W, 40 + p / W);
      w.colour = bg;
      wq.push_back(w);
    end
    @(negedge clk);
    laser_draw_done = 1'b0;
    destroyed_cars = '0;
    while (e_cnt + 1 != k + 7 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("reach_5th_erase", e_cnt + 1, k + 7);
    #2 resetn = 1'b0;
    #1;
    check("rst_wren", pix.erase_wren, 0);
    check("rst_coord_colour", {pix.coord, pix.colour}, 0);
    check("rst_done_busy", {erase_done, busy}, 0);
    check("rst_alive_kill", {cars_alive, kill_count}, 0);
    check("rst_writes_seen", wq.size(), 0);
    wq.delete();
    dq.delete();
    m_alive = '0;
    m_kill = 0;
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) car_xy[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_wren", pix.erase_wren, 0);
    check("reset_state", {erase_done, busy, cars_alive, kill_count}, 0);
    resetn = 1'b1;

    pulse_start();
    run_round(4'b0000, 1'b0, 1'b0);

    car_xy[2] = xy(10, 20);
    bg = 9'h1C7;
    run_round(4'b0100, 1'b0, 1'b0);

    car_xy[0] = xy($urandom_range(0, 150), $urandom_range(0, 110));
    car_xy[3] = xy($urandom_range(0, 150), $urandom_range(0, 110));
    bg = 9'($urandom);
    run_round(4'b1001, 1'b0, 1'b1);

    car_xy[1] = xy(158, 118);
    run_round(4'b0010, 1'b0, 1'b0);

    car_xy[1] = xy(50, 50);
    run_round(4'b0010, 1'b0, 1'b0);

    reset_mid_erase();
    run_round(4'b1111, 1'b0, 1'b0);

    car_xy[1] = xy(0, 0);
    car_xy[2] = xy(159, 119);
    run_round(4'b0110, 1'b1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) car_xy[i] = 15'($urandom);
      bg = 9'($urandom);
      run_round(4'($urandom), ($urandom % 3) == 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
